// File: rtl/tlb_search_arbiter.sv
// -----------------------------------------------------------------------------
// tlb_search_arbiter
//
// Lets the instruction-fetch side and the data side share one TLB search port.
// The arbiter accepts one lookup at a time:
//    IDLE   : arbitrate, pulse the winner's ack, latch its payload into s_*
//    LOOKUP : s_* held stable; capture the combinational TLB result into rsp_*
//             (retried while tlb_write is high)
//    RESP   : pulse the owner's rsp_valid for one cycle
//
// Arbitration (default build): fixed priority data > inst, with a starvation
// guard. After STARVE_LIMIT consecutive lost contested arbitrations, inst wins
// the next contested one.
// Optional build macro TLBARB_RR_EN: round-robin between the two sides when
// both request, based on the last grant.
//
// Ports:
//    clk, reset                  clock, asynchronous active-high reset
//    inst_req/vpn2/odd_page/asid instruction lookup request and payload
//    inst_cancel                 drop the instruction lookup / ignore inst_req
//    inst_ack, inst_rsp_valid    instruction accept pulse, result-valid pulse
//    data_*                      data-side equivalents
//    rsp_found/index/pfn/c/d/v   shared registered result, valid with rsp_valid
//    s_vpn2/odd_page/asid        TLB search port (registered)
//    s_found/index/pfn/c/d/v     TLB search result (combinational, same cycle)
//    tlb_write                   TLB entry written this cycle
//    busy                        arbiter not in IDLE
// -----------------------------------------------------------------------------
module tlb_search_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   // instruction requester
   input  logic        inst_req,
   input  logic [18:0] inst_vpn2,
   input  logic        inst_odd_page,
   input  logic [7:0]  inst_asid,
   input  logic        inst_cancel,
   output logic        inst_ack,
   output logic        inst_rsp_valid,
   // data requester
   input  logic        data_req,
   input  logic [18:0] data_vpn2,
   input  logic        data_odd_page,
   input  logic [7:0]  data_asid,
   input  logic        data_cancel,
   output logic        data_ack,
   output logic        data_rsp_valid,
   // shared result
   output logic        rsp_found,
   output logic [3:0]  rsp_index,
   output logic [19:0] rsp_pfn,
   output logic [2:0]  rsp_c,
   output logic        rsp_d,
   output logic        rsp_v,
   // TLB search port
   output logic [18:0] s_vpn2,
   output logic        s_odd_page,
   output logic [7:0]  s_asid,
   input  logic        s_found,
   input  logic [3:0]  s_index,
   input  logic [19:0] s_pfn,
   input  logic [2:0]  s_c,
   input  logic        s_d,
   input  logic        s_v,
   input  logic        tlb_write,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   state_t state_r;
   logic   owner_r;
   logic   rsp_valid_r;

`ifdef TLBARB_RR_EN
   logic   last_grant_r;
`else
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
   logic [CNT_W-1:0] starve_cnt_r;
`endif

   logic inst_pend_s;
   logic data_pend_s;
   logic grant_inst_s;
   logic grant_data_s;
   logic owner_cancel_s;

   // A cancelled requester is invisible to arbitration in that cycle.
   assign inst_pend_s = inst_req & ~inst_cancel;
   assign data_pend_s = data_req & ~data_cancel;

   // Grant decision, only taken in IDLE.
   always_comb begin
      grant_inst_s = 1'b0;
      grant_data_s = 1'b0;
      if (state_r == IDLE) begin
         if (inst_pend_s && data_pend_s) begin
`ifdef TLBARB_RR_EN
            if (last_grant_r == OWN_DATA) begin
               grant_inst_s = 1'b1;
            end else begin
               grant_data_s = 1'b1;
            end
`else
            if (starve_cnt_r == STARVE_MAX) begin
               grant_inst_s = 1'b1;
            end else begin
               grant_data_s = 1'b1;
            end
`endif
         end else if (inst_pend_s) begin
            grant_inst_s = 1'b1;
         end else if (data_pend_s) begin
            grant_data_s = 1'b1;
         end else begin
            grant_inst_s = 1'b0;
            grant_data_s = 1'b0;
         end
      end else begin
         grant_inst_s = 1'b0;
         grant_data_s = 1'b0;
      end
   end

   // The ack must land in the same IDLE cycle as the grant to keep the
   // ack(N) -> rsp_valid(N+2) latency, so it is decoded from the grant and
   // forced low while reset is held.
   assign inst_ack = grant_inst_s & ~reset;
   assign data_ack = grant_data_s & ~reset;

   assign owner_cancel_s = (owner_r == OWN_INST) ? inst_cancel : data_cancel;

   // The owner's cancel also kills the response pulse during RESP.
   assign inst_rsp_valid = rsp_valid_r & (owner_r == OWN_INST) & ~inst_cancel;
   assign data_rsp_valid = rsp_valid_r & (owner_r == OWN_DATA) & ~data_cancel;

   assign busy = (state_r != IDLE);

   // Lookup sequencer: arbitration state, search-port registers and result capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         owner_r      <= OWN_INST;
         rsp_valid_r  <= 1'b0;
         s_vpn2       <= 19'd0;
         s_odd_page   <= 1'b0;
         s_asid       <= 8'd0;
         rsp_found    <= 1'b0;
         rsp_index    <= 4'd0;
         rsp_pfn      <= 20'd0;
         rsp_c        <= 3'd0;
         rsp_d        <= 1'b0;
         rsp_v        <= 1'b0;
`ifdef TLBARB_RR_EN
         last_grant_r <= OWN_DATA;
`else
         starve_cnt_r <= '0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               rsp_valid_r <= 1'b0;
               if (grant_inst_s || grant_data_s) begin
                  owner_r    <= grant_data_s ? OWN_DATA : OWN_INST;
                  s_vpn2     <= grant_data_s ? data_vpn2     : inst_vpn2;
                  s_odd_page <= grant_data_s ? data_odd_page : inst_odd_page;
                  s_asid     <= grant_data_s ? data_asid     : inst_asid;
                  state_r    <= LOOKUP;
`ifdef TLBARB_RR_EN
                  last_grant_r <= grant_data_s ? OWN_DATA : OWN_INST;
`else
                  // Count only contested rounds that inst lost.
                  if (grant_inst_s) begin
                     starve_cnt_r <= '0;
                  end else if (inst_pend_s && (starve_cnt_r != STARVE_MAX)) begin
                     starve_cnt_r <= starve_cnt_r + CNT_W'(1);
                  end else begin
                     starve_cnt_r <= starve_cnt_r;
                  end
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            LOOKUP: begin
               if (owner_cancel_s) begin
                  state_r <= IDLE;
               end else if (tlb_write) begin
                  // The result may straddle the write; try again next cycle.
                  state_r <= LOOKUP;
               end else begin
                  rsp_found   <= s_found;
                  rsp_index   <= s_index;
                  rsp_pfn     <= s_pfn;
                  rsp_c       <= s_c;
                  rsp_d       <= s_d;
                  rsp_v       <= s_v;
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
               end
            end
            RESP: begin
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_search_arbiter.sv
module tb_tlb_search_arbiter;

   logic        clk;
   logic        reset;
   logic        inst_req, inst_odd_page, inst_cancel, inst_ack, inst_rsp_valid;
   logic [18:0] inst_vpn2;
   logic [7:0]  inst_asid;
   logic        data_req, data_odd_page, data_cancel, data_ack, data_rsp_valid;
   logic [18:0] data_vpn2;
   logic [7:0]  data_asid;
   logic        rsp_found, rsp_d, rsp_v;
   logic [3:0]  rsp_index;
   logic [19:0] rsp_pfn;
   logic [2:0]  rsp_c;
   logic [18:0] s_vpn2;
   logic        s_odd_page;
   logic [7:0]  s_asid;
   logic        s_found, s_d, s_v;
   logic [3:0]  s_index;
   logic [19:0] s_pfn;
   logic [2:0]  s_c;
   logic        tlb_write;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   tlb_search_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_vpn2(inst_vpn2), .inst_odd_page(inst_odd_page),
      .inst_asid(inst_asid), .inst_cancel(inst_cancel),
      .inst_ack(inst_ack), .inst_rsp_valid(inst_rsp_valid),
      .data_req(data_req), .data_vpn2(data_vpn2), .data_odd_page(data_odd_page),
      .data_asid(data_asid), .data_cancel(data_cancel),
      .data_ack(data_ack), .data_rsp_valid(data_rsp_valid),
      .rsp_found(rsp_found), .rsp_index(rsp_index), .rsp_pfn(rsp_pfn),
      .rsp_c(rsp_c), .rsp_d(rsp_d), .rsp_v(rsp_v),
      .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
      .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn),
      .s_c(s_c), .s_d(s_d), .s_v(s_v),
      .tlb_write(tlb_write), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Inputs change on the falling edge; outputs are checked 1 ns later.
   initial begin
      reset = 1'b1;
      inst_req = 1'b0; inst_vpn2 = 19'd0; inst_odd_page = 1'b0; inst_asid = 8'd0; inst_cancel = 1'b0;
      data_req = 1'b0; data_vpn2 = 19'd0; data_odd_page = 1'b0; data_asid = 8'd0; data_cancel = 1'b0;
      s_found = 1'b0; s_index = 4'd0; s_pfn = 20'd0; s_c = 3'd0; s_d = 1'b0; s_v = 1'b0;
      tlb_write = 1'b0;

      // ---- reset state (a request held during reset must not be acked) ----
      @(negedge clk); @(negedge clk);
      inst_req = 1'b1;
      #1;
      chk("rst_busy",     32'(busy), 32'd0);
      chk("rst_inst_ack", 32'(inst_ack), 32'd0);
      chk("rst_s_vpn2",   32'(s_vpn2), 32'd0);
      chk("rst_rsp_pfn",  32'(rsp_pfn), 32'd0);
      @(negedge clk);
      inst_req = 1'b0;
      reset = 1'b0;

      // ---- single instruction lookup ----
      @(negedge clk);
      inst_req = 1'b1; inst_vpn2 = 19'h12345; inst_odd_page = 1'b1; inst_asid = 8'h07;
      s_found = 1'b1; s_index = 4'd3; s_pfn = 20'hABCDE; s_c = 3'd2; s_d = 1'b1; s_v = 1'b1;
      #1;
      chk("t1_ack_N",   32'(inst_ack), 32'd1);
      chk("t1_dack_N",  32'(data_ack), 32'd0);
      @(negedge clk);
      inst_req = 1'b0;
      #1;
      chk("t1_s_vpn2",  32'(s_vpn2), 32'h12345);
      chk("t1_s_odd",   32'(s_odd_page), 32'd1);
      chk("t1_s_asid",  32'(s_asid), 32'h07);
      chk("t1_busy",    32'(busy), 32'd1);
      chk("t1_rv_N1",   32'(inst_rsp_valid), 32'd0);
      @(negedge clk); #1;
      chk("t1_rv_N2",   32'(inst_rsp_valid), 32'd1);
      chk("t1_drv_N2",  32'(data_rsp_valid), 32'd0);
      chk("t1_pfn",     32'(rsp_pfn), 32'hABCDE);
      chk("t1_index",   32'(rsp_index), 32'd3);
      chk("t1_found",   32'(rsp_found), 32'd1);
      chk("t1_c",       32'(rsp_c), 32'd2);
      chk("t1_v",       32'(rsp_v), 32'd1);
      @(negedge clk); #1;
      chk("t1_rv_N3",   32'(inst_rsp_valid), 32'd0);
      chk("t1_idle",    32'(busy), 32'd0);

      // ---- both requesters held: starvation guard / round robin ----
      @(negedge clk);
      inst_req = 1'b1; inst_vpn2 = 19'h00111;
      data_req = 1'b1; data_vpn2 = 19'h00222;
      for (int g = 0; g < 10; g++) begin
         logic exp_data;
`ifdef TLBARB_RR_EN
         exp_data = ((g % 2) == 0);
`else
         exp_data = !((g == 4) || (g == 9));
`endif
         #1;
         chk($sformatf("arb%0d_dack", g), 32'(data_ack), 32'(exp_data));
         chk($sformatf("arb%0d_iack", g), 32'(inst_ack), 32'(!exp_data));
         @(negedge clk);
         @(negedge clk); #1;
         chk($sformatf("arb%0d_drv", g), 32'(data_rsp_valid), 32'(exp_data));
         chk($sformatf("arb%0d_irv", g), 32'(inst_rsp_valid), 32'(!exp_data));
         @(negedge clk);
      end
      inst_req = 1'b0; data_req = 1'b0;

      // ---- data lookup with tlb_write held two cycles in LOOKUP ----
      @(negedge clk);
      s_pfn = 20'h11111;
      data_req = 1'b1; data_vpn2 = 19'h0ABCD; data_odd_page = 1'b0; data_asid = 8'h22;
      #1;
      chk("tw_ack_N",   32'(data_ack), 32'd1);
      @(negedge clk);
      data_req = 1'b0; tlb_write = 1'b1;
      #1;
      chk("tw_rv_N1",   32'(data_rsp_valid), 32'd0);
      @(negedge clk); #1;
      chk("tw_rv_N2",   32'(data_rsp_valid), 32'd0);
      @(negedge clk);
      tlb_write = 1'b0; s_pfn = 20'h00055;
      #1;
      chk("tw_rv_N3",   32'(data_rsp_valid), 32'd0);
      chk("tw_busy_N3", 32'(busy), 32'd1);
      @(negedge clk); #1;
      chk("tw_rv_N4",   32'(data_rsp_valid), 32'd1);
      chk("tw_pfn_N4",  32'(rsp_pfn), 32'h00055);
      chk("tw_irv_N4",  32'(inst_rsp_valid), 32'd0);

      // ---- inst cancel in LOOKUP with data pending ----
      @(negedge clk);
      inst_req = 1'b1; inst_vpn2 = 19'h00001;
      #1;
      chk("cn_ack_N",   32'(inst_ack), 32'd1);
      @(negedge clk);
      inst_req = 1'b0; inst_cancel = 1'b1; data_req = 1'b1; data_vpn2 = 19'h00333;
      #1;
      chk("cn_dack_N1", 32'(data_ack), 32'd0);
      @(negedge clk);
      inst_cancel = 1'b0;
      #1;
      chk("cn_busy_N2", 32'(busy), 32'd0);
      chk("cn_irv_N2",  32'(inst_rsp_valid), 32'd0);
      chk("cn_dack_N2", 32'(data_ack), 32'd1);
      @(negedge clk);
      data_req = 1'b0;
      #1;
      chk("cn_svpn_N3", 32'(s_vpn2), 32'h00333);
      @(negedge clk); #1;
      chk("cn_drv_N4",  32'(data_rsp_valid), 32'd1);
      chk("cn_irv_N4",  32'(inst_rsp_valid), 32'd0);

      // ---- cancel in IDLE suppresses the request ----
      @(negedge clk);
      inst_req = 1'b1; inst_cancel = 1'b1;
      #1;
      chk("ci_ack",     32'(inst_ack), 32'd0);
      @(negedge clk);
      inst_req = 1'b0; inst_cancel = 1'b0;
      #1;
      chk("ci_busy",    32'(busy), 32'd0);

      // ---- tlb_write in IDLE and RESP has no effect ----
      @(negedge clk);
      s_pfn = 20'h22222;
      inst_req = 1'b1; inst_vpn2 = 19'h04444; tlb_write = 1'b1;
      #1;
      chk("wr_ack_N",   32'(inst_ack), 32'd1);
      @(negedge clk);
      inst_req = 1'b0; tlb_write = 1'b0;
      @(negedge clk);
      tlb_write = 1'b1; s_pfn = 20'h33333;
      #1;
      chk("wr_rv_N2",   32'(inst_rsp_valid), 32'd1);
      chk("wr_pfn_N2",  32'(rsp_pfn), 32'h22222);
      @(negedge clk);
      tlb_write = 1'b0;
      #1;
      chk("wr_idle",    32'(busy), 32'd0);
      chk("wr_pfn_hold",32'(rsp_pfn), 32'h22222);

      // ---- asynchronous reset in the middle of LOOKUP ----
      @(negedge clk);
      inst_req = 1'b1; inst_vpn2 = 19'h7FFFF;
      #1;
      chk("ar_ack_N",   32'(inst_ack), 32'd1);
      @(negedge clk);
      inst_req = 1'b0;
      #1;
      chk("ar_busy_N1", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_busy",    32'(busy), 32'd0);
      chk("ar_s_vpn2",  32'(s_vpn2), 32'd0);
      chk("ar_rsp_pfn", 32'(rsp_pfn), 32'd0);
      chk("ar_irv",     32'(inst_rsp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ar_irv_1",   32'(inst_rsp_valid), 32'd0);
      @(negedge clk); #1;
      chk("ar_irv_2",   32'(inst_rsp_valid), 32'd0);
      chk("ar_busy_2",  32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
